multi_channel_histogram_engine: RTL
===================================

// Module: multi_channel_histogram_engine
// PURPOSE
// - Parametrised successor of the single-channel histogram core: bins pulse widths from NUM_CHANNELS sources into one
//   shared bin memory, with per-channel bin banks, saturating counts and a conflict-free read-modify-write pipeline.
// - Sits in the clk_slowest domain between the CDC FIFO read side and the UART controller.
// - Provides start/stop gating, a PC-commanded clear sweep and a random-access readout port for the UART controller.
// PARAMETERS
// - NUM_CHANNELS  4   number of pulse sources; CH_W = max(1,$clog2(NUM_CHANNELS)) (localparam)
// - ADDR_WIDTH    9   log2 bins per channel; 512 bins per channel
// - DATA_WIDTH    16  bin counter width
// - PW_WIDTH      16  width of incoming pulse-width sample
// - BIN_SHIFT     0   bin index = s_width >> BIN_SHIFT
// PORTS
// - clk            in   1           histogram clock (clk_slowest)
// - reset          in   1           asynchronous, active-high reset
// - enable         in   1           1 = accept samples (synchronised start/stop from PC)
// - s_valid        in   1           sample valid
// - s_ready        out  1           sample accepted when s_valid & s_ready
// - s_channel      in   CH_W        source channel of sample
// - s_width        in   PW_WIDTH    measured pulse width
// - clear_req      in   1           one-cycle pulse: zero all bins of all channels
// - rd_req         in   1           one-cycle readout request
// - rd_channel     in   CH_W        readout channel
// - rd_bin         in   ADDR_WIDTH  readout bin
// - rd_valid       out  1           rd_data valid (one cycle)
// - rd_data        out  DATA_WIDTH  bin count
// - busy           out  1           INIT or CLEAR sweep in progress
// - bram_reset_done out 1           high from end of first INIT sweep until next reset
// - dropped_count  out  DATA_WIDTH  saturating count of discarded samples
// BEHAVIOUR
// - Memory: NUM_CHANNELS*2^ADDR_WIDTH words, address {channel,bin}; 1-cycle synchronous read, 1 write port.
// - Reset values: s_ready=0, rd_valid=0, rd_data=0, busy=1, bram_reset_done=0, dropped_count=0, pipeline regs empty.
// - FSM: INIT -> RUN -> (clear_req) DRAIN -> CLEAR -> RUN. INIT and CLEAR write 0 to one address per cycle, ascending
//   from 0; sweep = NUM_CHANNELS*2^ADDR_WIDTH cycles. bram_reset_done rises the cycle after INIT's last write.
// - s_ready = (state==RUN) & enable & ~rd_req & ~clear_req. enable=0: no accepts, pipeline still drains.
// - Sample pipeline: A accept/compute bin; R read issued; W write min(count+1, 2^DATA_WIDTH-1). Write at cycle +2.
// - Hazard: if W and R hold same address in the same cycle, R uses W's written value (forward); back-to-back
//   identical samples each count exactly once. Saturated bins stay at all-ones.
// - Bin out of range (s_width>>BIN_SHIFT >= 2^ADDR_WIDTH) or s_channel >= NUM_CHANNELS: see CONFIGURATION.
//   Channel out of range is always dropped: dropped_count += 1 (saturating), no memory access.
// - Readout: rd_req in RUN only; takes memory read slot that cycle (s_ready low); rd_valid/rd_data exactly 2 cycles
//   later; forwarding applies so a read sees any increment written up to and including its read cycle.
//   rd_req while busy: ignored, no rd_valid. rd_data holds last value between reads.
// - clear_req in RUN: DRAIN until pipeline empty (<=2 cycles), then CLEAR sweep; dropped_count also zeroed.
//   clear_req while busy is ignored. Simultaneous clear_req and rd_req: clear wins, read ignored.
// - reset mid-operation: all in-flight samples and reads lost, state -> INIT, bram_reset_done drops immediately.
// CONFIGURATION
// - HIST_OVERFLOW_BIN_EN defined: out-of-range bin index clamped to bin 2^ADDR_WIDTH-1 of its channel and counted.
// - Not defined: out-of-range sample discarded, dropped_count += 1 (saturating); no memory access.
// TESTING
// - Reset, NUM_CHANNELS=4, ADDR_WIDTH=9 -> busy=1 for 2048 cycles, bram_reset_done=1 at cycle 2049, all reads 0.
// - 10 back-to-back samples ch2 width 37 -> read (2,37)=10; (2,36),(1,37) = 0; no lost updates.
// - 70000 samples ch0 width 5, DATA_WIDTH=16 -> (0,5)=65535, no wrap.
// - Sample ch1 width 600: with HIST_OVERFLOW_BIN_EN (1,511)=1, dropped=0; without (1,511)=0, dropped=1.
// - Samples to ch3 bin 9, clear_req mid-stream, then read -> all bins 0, dropped_count=0, busy for 2048 cycles.
// - rd_req on same cycle a sample to that bin is in W -> rd_data includes increment, rd_valid exactly 2 cycles later.

Source files
------------

// File: rtl/multi_channel_histogram_engine.sv
// Multi-channel pulse-width histogram: shared bin memory, per-channel banks,
// saturating counts, forwarded read-modify-write pipeline and readout port.
// Optional macro HIST_OVERFLOW_BIN_EN: clamp out-of-range bins into the last
// bin of the channel instead of dropping the sample.
// Ports: clk, reset (async, active high), enable, s_valid/s_ready/s_channel/
// s_width (sample in), clear_req, rd_req/rd_channel/rd_bin (readout request),
// rd_valid/rd_data (readout result), busy, bram_reset_done, dropped_count.
module multi_channel_histogram_engine #(
  parameter int NUM_CHANNELS = 4,
  parameter int ADDR_WIDTH   = 9,
  parameter int DATA_WIDTH   = 16,
  parameter int PW_WIDTH     = 16,
  parameter int BIN_SHIFT    = 0,
  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [CH_W-1:0]       s_channel,
  input  logic [PW_WIDTH-1:0]   s_width,
  input  logic                  clear_req,
  input  logic                  rd_req,
  input  logic [CH_W-1:0]       rd_channel,
  input  logic [ADDR_WIDTH-1:0] rd_bin,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  bram_reset_done,
  output logic [DATA_WIDTH-1:0] dropped_count
);

  localparam int MW    = CH_W + ADDR_WIDTH;
  localparam int DEPTH = NUM_CHANNELS << ADDR_WIDTH;
  localparam int unsigned NBINS = 32'd1 << ADDR_WIDTH;
  localparam int unsigned NCH   = NUM_CHANNELS;
  localparam logic [MW-1:0] LAST = MW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_INIT,
    S_RUN,
    S_DRAIN,
    S_CLEAR
  } state_t;

  state_t state_q, state_d;
  logic [MW-1:0] cnt_q, cnt_d;
  logic done_q, done_d;
  logic [DATA_WIDTH-1:0] drop_q, drop_d;

  // R stage: memory read in flight; W stage: read data back, write issued
  logic r_smp_q, r_smp_d, r_rd_q, r_rd_d;
  logic [MW-1:0] r_addr_q, r_addr_d;
  logic w_smp_q, w_smp_d, w_rd_q, w_rd_d;
  logic [MW-1:0] w_addr_q, w_addr_d;

  // Bypass of a write landing on the address being read in the same cycle
  logic fwd_hit_q, fwd_hit_d;
  logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] mem_dout;

  logic in_run, sweep, acc, rd_go, smp_ok, smp_drop;
  logic bin_oor, ch_oor;
  logic [PW_WIDTH-1:0] bin_full;
  logic [ADDR_WIDTH-1:0] bin_sel;
  logic [MW-1:0] a_addr;
  logic [DATA_WIDTH-1:0] cur, inc;
  logic mem_we;
  logic [MW-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  assign in_run = (state_q == S_RUN);
  assign sweep  = (state_q == S_INIT) | (state_q == S_CLEAR);
  assign s_ready = in_run & enable & ~rd_req & ~clear_req;
  assign busy = sweep;
  assign bram_reset_done = done_q;
  assign dropped_count = drop_q;
  assign rd_valid = w_rd_q;
  assign rd_data = w_rd_q ? cur : hold_q;

  always_comb begin
    acc      = s_valid & s_ready;
    rd_go    = in_run & rd_req & ~clear_req;
    bin_full = s_width >> BIN_SHIFT;
    bin_oor  = 32'(bin_full) >= NBINS;
    ch_oor   = 32'(s_channel) >= NCH;
    bin_sel  = ADDR_WIDTH'(bin_full);
`ifdef HIST_OVERFLOW_BIN_EN
    if (bin_oor) bin_sel = '1;
    smp_ok = acc & ~ch_oor;
`else
    smp_ok = acc & ~ch_oor & ~bin_oor;
`endif
    smp_drop = acc & ~smp_ok;
    a_addr = rd_go ? {rd_channel, rd_bin} : {s_channel, bin_sel};

    r_smp_d  = smp_ok;
    r_rd_d   = rd_go;
    r_addr_d = a_addr;
    w_smp_d  = r_smp_q;
    w_rd_d   = r_rd_q;
    w_addr_d = r_addr_q;

    cur = fwd_hit_q ? fwd_data_q : mem_dout;
    inc = (&cur) ? cur : cur + 1'b1;

    mem_we    = sweep | w_smp_q;
    mem_waddr = sweep ? cnt_q : w_addr_q;
    mem_wdata = sweep ? '0 : inc;

    fwd_hit_d  = mem_we & (mem_waddr == r_addr_q);
    fwd_data_d = mem_wdata;
    hold_d     = w_rd_q ? cur : hold_q;

    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    drop_d  = drop_q;
    if (smp_drop & ~(&drop_q)) drop_d = drop_q + 1'b1;

    unique case (state_q)
      S_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (clear_req) begin
          drop_d  = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (~r_smp_q & ~r_rd_q & ~w_smp_q & ~w_rd_q)
          state_d = S_CLEAR;
      end
      S_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_INIT;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      drop_q     <= '0;
      r_smp_q    <= 1'b0;
      r_rd_q     <= 1'b0;
      r_addr_q   <= '0;
      w_smp_q    <= 1'b0;
      w_rd_q     <= 1'b0;
      w_addr_q   <= '0;
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      drop_q     <= drop_d;
      r_smp_q    <= r_smp_d;
      r_rd_q     <= r_rd_d;
      r_addr_q   <= r_addr_d;
      w_smp_q    <= w_smp_d;
      w_rd_q     <= w_rd_d;
      w_addr_q   <= w_addr_d;
      fwd_hit_q  <= fwd_hit_d;
      fwd_data_q <= fwd_data_d;
      hold_q     <= hold_d;
    end
  end

  // Plain RAM: contents are defined by the INIT sweep, not by reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    mem_dout <= mem[r_addr_q];
  end

endmodule
